fifo_write_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `fifo` write port among `CLIENTS` producers. Grants are held for a burst, which ends on a client-marked last word, on a configurable beat limit, or when the client withdraws. Writes are throttled by the FIFO `full` flag. It sits directly in front of a `fifo` instance, driving its `datain` and `write` inputs, while a separate consumer owns `read`.

---
 rtl/fifo_write_arbiter_pkg.sv | 11 +
 rtl/fifo_write_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared FIFO-side types for the write-port arbiter
package fifoPkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arbState;

  // A zero beat limit means unlimited bursts; keep the counter at least one bit wide.
  function automatic int beats_width(input int maxburst);
    return (maxburst > 0) ? $clog2(maxburst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin picker, first request at or above ptr
module rr_priority_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index,
  output logic [N-1:0]  onehot
);

  int j;

  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        index     = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_write_arbiter
  import fifoPkg::*;
#(
  parameter int CLIENTS  = 4,
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CLIENTS-1:0] req,
  input  logic [CLIENTS-1:0] last,
  input  logic [WIDTH-1:0]   data [CLIENTS],
  output logic [CLIENTS-1:0] ack,
  output logic [CLIENTS-1:0] grant,
  output logic               busy,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [WIDTH-1:0]   fifo_datain
);

  localparam int IW = $clog2(CLIENTS);
  localparam int BW = beats_width(MAXBURST);
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(MAXBURST);
  localparam logic [IW-1:0] LAST_IDX   = IW'(CLIENTS - 1);

  arbState state, state_next;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] beats;

  logic               pick_valid;
  logic [IW-1:0]      pick_index;
  logic [CLIENTS-1:0] pick_onehot;
  logic               beat;
  logic               burst_done;

  rr_priority_pick #(.N(CLIENTS)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_index),
    .onehot (pick_onehot)
  );

  // Reset gates the beat combinationally so an abandoned burst never leaks a word.
  assign beat = (state == ARB_BURST) && req[owner] && !fifo_full && !reset;

  always_comb begin
    burst_done = 1'b0;
    if (state == ARB_BURST) begin
      if (!req[owner])
        burst_done = 1'b1;
      else if (beat && last[owner])
        burst_done = 1'b1;
      else if (beat && (MAXBURST != 0) && ((beats + 1'b1) == BEAT_LIMIT))
        burst_done = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (pick_valid) state_next = ARB_BURST;
      ARB_BURST: if (burst_done) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner <= pick_index;
            grant <= pick_onehot;
            beats <= '0;
            busy  <= 1'b1;
          end
        end
        ARB_BURST: begin
          if (beat) beats <= beats + 1'b1;
          if (burst_done) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack         = '0;
    fifo_write  = beat;
    fifo_datain = '0;
    if (beat) ack[owner] = 1'b1;
    if ((state == ARB_BURST) && !reset) fifo_datain = data[owner];
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for the round-robin FIFO write arbiter
module tb_fifo_write_arbiter;

  localparam int CLIENTS  = 4;
  localparam int WIDTH    = 32;
  localparam int MAXBURST = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [CLIENTS-1:0] req;
  logic [CLIENTS-1:0] last;
  logic [WIDTH-1:0]   data [CLIENTS];
  logic [CLIENTS-1:0] ack;
  logic [CLIENTS-1:0] grant;
  logic               busy;
  logic               fifo_full;
  logic               fifo_write;
  logic [WIDTH-1:0]   fifo_datain;

  fifo_write_arbiter #(.CLIENTS(CLIENTS), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .last        (last),
    .data        (data),
    .ack         (ack),
    .grant       (grant),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_datain (fifo_datain)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Client model: per-client word list, head pointer and enable.
  logic [31:0] cw [4][16];
  logic        cl [4][16];
  int          head [4];
  int          cnt  [4];
  logic        en   [4];

  logic [33:0] sb [$];
  int order [$];
  int gaps  [$];
  int lens  [$];
  int nowrite, idle_run, cur_len;
  logic seen;
  logic [3:0] prev_g;

  logic [3:0]  g_s, a_s;
  logic        w_s, b_s;
  logic [31:0] d_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int c, input int k);
    return {8'hA0 + 8'(c), 16'h5A00, 8'(k)};
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic update_drives();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && head[i] < cnt[i]) begin
        req[i]  = 1'b1;
        data[i] = cw[i][head[i]];
        last[i] = cl[i][head[i]];
      end else begin
        req[i]  = 1'b0;
        data[i] = '0;
        last[i] = 1'b0;
      end
    end
  endtask

  task automatic load_client(input int c, input int n, input logic [15:0] lm);
    for (int k = 0; k < n; k++) begin
      cw[c][k] = mk(c, k);
      cl[c][k] = lm[k];
    end
    cnt[c]  = n;
    head[c] = 0;
    en[c]   = 1'b1;
  endtask

  task automatic push_exp(input int c, input int from, input int upto);
    for (int k = from; k < upto; k++) sb.push_back({2'(c), mk(c, k)});
  endtask

  task automatic reset_tracking();
    order.delete();
    gaps.delete();
    lens.delete();
    nowrite  = 0;
    idle_run = 0;
    cur_len  = 0;
    seen     = 1'b0;
    prev_g   = '0;
  endtask

  // One clock: sample and score at negedge, then let clients consume acked words.
  task automatic cycle();
    logic [33:0] e;
    @(negedge clk);
    g_s = grant;
    a_s = ack;
    w_s = fifo_write;
    b_s = busy;
    d_s = fifo_datain;
    if (w_s) begin
      if (sb.size() == 0) begin
        check("unexpected_write", w_s, 0);
      end else begin
        e = sb.pop_front();
        check("datain", d_s, e[31:0]);
        check("ack_owner", a_s, 4'b0001 << e[33:32]);
        check("grant_owner", g_s, 4'b0001 << e[33:32]);
      end
    end else begin
      check("ack_idle", a_s, 0);
    end
    if (g_s != 0 && prev_g == 0) begin
      order.push_back(oh_idx(g_s));
      if (seen) gaps.push_back(idle_run);
      seen     = 1'b1;
      idle_run = 0;
      cur_len  = 0;
    end
    if (g_s == 0 && prev_g != 0) lens.push_back(cur_len);
    if (g_s == 0 && seen) idle_run++;
    if (g_s != 0) begin
      if (w_s) cur_len++;
      else     nowrite++;
    end
    prev_g = g_s;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (a_s[i]) head[i]++;
    update_drives();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i]   = 1'b0;
      cnt[i]  = 0;
      head[i] = 0;
    end
    sb.delete();
    update_drives();
    cycle();
    cycle();
    reset = 1'b0;
    reset_tracking();
  endtask

  task automatic run_until(input int budget);
    int n = 0;
    while ((sb.size() > 0 || g_s != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drained", sb.size(), 0);
    check("idle_at_end", g_s, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req       = '0;
    last      = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = '0;

    // Reset state
    do_reset();
    cycle();
    check("rst_grant", g_s, 0);
    check("rst_busy", b_s, 0);
    check("rst_write", w_s, 0);
    check("rst_datain", d_s, 0);
    check("rst_rr_ptr", dut.rr_ptr, 0);

    // Single client, burst ended by last
    do_reset();
    load_client(2, 3, 16'b100);
    push_exp(2, 0, 3);
    update_drives();
    cycle(); check("t1_grant_wait", g_s, 0);
    cycle(); check("t1_grant", g_s, 4'b0100); check("t1_busy", b_s, 1); check("t1_w0", w_s, 1);
    cycle(); check("t1_w1", w_s, 1);
    cycle(); check("t1_w2", w_s, 1);
    cycle();
    check("t1_idle_grant", g_s, 0);
    check("t1_idle_busy", b_s, 0);
    check("t1_idle_write", w_s, 0);
    check("t1_rr_ptr", dut.rr_ptr, 3);

    // Round-robin rotation, two words per turn
    do_reset();
    for (int c = 0; c < 4; c++) load_client(c, 4, 16'b1010);
    for (int t = 0; t < 2; t++)
      for (int c = 0; c < 4; c++) push_exp(c, 2 * t, 2 * t + 2);
    update_drives();
    run_until(80);
    check("t2_bursts", order.size(), 8);
    for (int i = 0; i < order.size(); i++) check("t2_order", order[i], i % 4);
    for (int i = 0; i < gaps.size(); i++) check("t2_gap", gaps[i], 1);
    for (int i = 0; i < lens.size(); i++) check("t2_len", lens[i], 2);
    check("t2_no_bubbles", nowrite, 0);

    // Beat limit
    do_reset();
    load_client(0, 12, 16'h0000);
    load_client(1, 2, 16'b10);
    push_exp(0, 0, 8);
    push_exp(1, 0, 2);
    push_exp(0, 8, 12);
    update_drives();
    run_until(60);
    check("t3_bursts", lens.size(), 3);
    if (lens.size() == 3) begin
      check("t3_len0", lens[0], 8);
      check("t3_len1", lens[1], 2);
      check("t3_len2", lens[2], 4);
      check("t3_order0", order[0], 0);
      check("t3_order1", order[1], 1);
      check("t3_order2", order[2], 0);
    end

    // Full stall mid-burst
    do_reset();
    load_client(1, 6, 16'b100000);
    push_exp(1, 0, 6);
    update_drives();
    cycle(); cycle(); cycle();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_stall_write", w_s, 0);
      check("t4_stall_grant", g_s, 4'b0010);
    end
    check("t4_beats_held", dut.beats, 2);
    fifo_full = 1'b0;
    cycle(); check("t4_resume", w_s, 1);
    run_until(20);
    check("t4_stall_cycles", nowrite, 5);
    check("t4_len", lens.size() == 1 ? lens[0] : -1, 6);

    // Withdrawal after two beats
    do_reset();
    load_client(1, 5, 16'h0000);
    push_exp(1, 0, 2);
    update_drives();
    cycle(); cycle(); cycle();
    en[1] = 1'b0;
    update_drives();
    cycle();
    check("t5_withdraw_write", w_s, 0);
    check("t5_withdraw_grant", g_s, 4'b0010);
    cycle();
    check("t5_idle_grant", g_s, 0);
    check("t5_idle_busy", b_s, 0);
    check("t5_rr_ptr", dut.rr_ptr, 2);
    check("t5_sb_empty", sb.size(), 0);

    // Reset during a beat, then re-arbitration from client 0
    do_reset();
    load_client(1, 6, 16'b100000);
    push_exp(1, 0, 1);
    update_drives();
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    check("t6_reset_write", w_s, 0);
    check("t6_reset_ack", a_s, 0);
    check("t6_reset_datain", d_s, 0);
    reset = 1'b0;
    load_client(0, 2, 16'b10);
    update_drives();
    cycle();
    check("t6_after_grant", g_s, 0);
    check("t6_after_busy", b_s, 0);
    check("t6_after_write", w_s, 0);
    check("t6_after_datain", d_s, 0);
    check("t6_after_rr_ptr", dut.rr_ptr, 0);
    reset_tracking();
    push_exp(0, 0, 2);
    push_exp(1, 1, 6);
    run_until(40);
    check("t6_bursts", order.size(), 2);
    if (order.size() == 2) begin
      check("t6_first", order[0], 0);
      check("t6_second", order[1], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
